// File: rtl/sorting_network_stream.sv
// Streaming odd-even transposition sorter with per-vector direction, optional
// signed compare, argsort index tags and a stall-all valid/ready pipeline.
module sorting_network_stream #(
  parameter int unsigned NUMBER_WIDTH   = 10,
  parameter int unsigned NUMBERS_AMOUNT = 10,
  parameter bit          SIGNED         = 1'b0,
  localparam int unsigned INDEX_WIDTH   = $clog2(NUMBERS_AMOUNT)
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic [NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0]   data_i,
  input  logic                                          descend_i,
  input  logic                                          data_valid_i,
  output logic                                          data_ready_o,
  output logic [NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0]   data_o,
  output logic [NUMBERS_AMOUNT-1:0][INDEX_WIDTH-1:0]    index_o,
  output logic                                          descend_o,
  output logic                                          data_valid_o,
  input  logic                                          data_ready_i
);

  localparam int unsigned N = NUMBERS_AMOUNT;

  typedef logic [N-1:0][NUMBER_WIDTH-1:0] vec_t;
  typedef logic [N-1:0][INDEX_WIDTH-1:0]  idx_t;

  vec_t         val_q [N];
  vec_t         val_d [N];
  idx_t         idx_q [N];
  idx_t         idx_d [N];
  vec_t         src_val [N];
  idx_t         src_idx [N];
  logic [N-1:0] vld_q, vld_d;
  logic [N-1:0] desc_q, desc_d;
  logic         en_c;

  function automatic logic greater(input logic [NUMBER_WIDTH-1:0] a,
                                   input logic [NUMBER_WIDTH-1:0] b);
    if (SIGNED) return $signed(a) > $signed(b);
    return a > b;
  endfunction

  // Whole pipeline advances together; a full output stage blocks everything.
  assign en_c         = !vld_q[N-1] || data_ready_i;
  assign data_ready_o = en_c;

  assign vld_d  = {vld_q[N-2:0], data_valid_i};
  assign desc_d = {desc_q[N-2:0], descend_i};

  // Stage inputs: stage 0 sees the incoming vector with fresh index tags.
  always_comb begin
    src_val[0] = data_i;
    for (int i = 0; i < int'(N); i++) begin
      src_idx[0][i] = INDEX_WIDTH'(i);
    end
    for (int s = 1; s < int'(N); s++) begin
      src_val[s] = val_q[s-1];
      src_idx[s] = idx_q[s-1];
    end
  end

  // Compare-exchange layer per stage; strict compares keep the sort stable.
  always_comb begin : exchange
    vec_t                    v;
    idx_t                    x;
    logic [NUMBER_WIDTH-1:0] tv;
    logic [INDEX_WIDTH-1:0]  tx;
    logic                    sw;
    for (int s = 0; s < int'(N); s++) begin
      v = src_val[s];
      x = src_idx[s];
      for (int p = s % 2; p < int'(N) - 1; p += 2) begin
        sw = desc_d[s] ? greater(v[p+1], v[p]) : greater(v[p], v[p+1]);
        tv = v[p];
        tx = x[p];
        if (sw) begin
          v[p]   = v[p+1];
          v[p+1] = tv;
          x[p]   = x[p+1];
          x[p+1] = tx;
        end
      end
      val_d[s] = v;
      idx_d[s] = x;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < int'(N); s++) begin
        val_q[s] <= '0;
        idx_q[s] <= '0;
      end
      vld_q  <= '0;
      desc_q <= '0;
    end else if (en_c) begin
      val_q  <= val_d;
      idx_q  <= idx_d;
      vld_q  <= vld_d;
      desc_q <= desc_d;
    end
  end

  assign data_o       = val_q[N-1];
  assign index_o      = idx_q[N-1];
  assign descend_o    = desc_q[N-1];
  assign data_valid_o = vld_q[N-1];

endmodule

// File: tb/tb_sorting_network_stream.sv
// Directed bench for sorting_network_stream: unsigned DUT plus a SIGNED=1 twin
// driven in lockstep from the same stimulus.
module tb_sorting_network_stream;

  localparam int unsigned W  = 10;
  localparam int unsigned N  = 10;
  localparam int unsigned IW = 4;

  typedef logic [N-1:0][W-1:0]  vec_t;
  typedef logic [N-1:0][IW-1:0] ivec_t;

  logic  clk = 1'b0;
  logic  rst;
  vec_t  din;
  logic  desc_in, vld_in, rdy_in;
  logic  u_rdy, u_desc, u_vld;
  vec_t  u_data;
  ivec_t u_idx;
  logic  s_rdy, s_desc, s_vld;
  vec_t  s_data;
  ivec_t s_idx;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sorting_network_stream #(.NUMBER_WIDTH(W), .NUMBERS_AMOUNT(N), .SIGNED(1'b0)) u_dut (
    .clk_i(clk), .rst_i(rst), .data_i(din), .descend_i(desc_in),
    .data_valid_i(vld_in), .data_ready_o(u_rdy), .data_o(u_data),
    .index_o(u_idx), .descend_o(u_desc), .data_valid_o(u_vld),
    .data_ready_i(rdy_in));

  sorting_network_stream #(.NUMBER_WIDTH(W), .NUMBERS_AMOUNT(N), .SIGNED(1'b1)) s_dut (
    .clk_i(clk), .rst_i(rst), .data_i(din), .descend_i(desc_in),
    .data_valid_i(vld_in), .data_ready_o(s_rdy), .data_o(s_data),
    .index_o(s_idx), .descend_o(s_desc), .data_valid_o(s_vld),
    .data_ready_i(rdy_in));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send one vector, expect it after N-1 further edges for exactly one cycle.
  task automatic run_vec(input string tag, input vec_t v, input logic d,
                         input vec_t ed, input ivec_t ei,
                         input vec_t esd, input ivec_t esi);
    int n;
    check({tag, "_rdy"}, 128'(u_rdy), 128'(1));
    din = v; desc_in = d; vld_in = 1'b1;
    tick();
    vld_in = 1'b0; din = '0; desc_in = 1'b0;
    n = 0;
    while (!u_vld && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_lat"},   128'(n),      128'(N - 1));
    check({tag, "_data"},  128'(u_data), 128'(ed));
    check({tag, "_idx"},   128'(u_idx),  128'(ei));
    check({tag, "_desc"},  128'(u_desc), 128'(d));
    check({tag, "_sdata"}, 128'(s_data), 128'(esd));
    check({tag, "_sidx"},  128'(s_idx),  128'(esi));
    check({tag, "_svld"},  128'(s_vld),  128'(1));
    tick();
    check({tag, "_once"},  128'(u_vld),  128'(0));
  endtask

  vec_t  rev_v, seq_v, five_v, alt_v, alt_asc_d, alt_desc_d, sg_v, sg_ud, sg_sd;
  ivec_t rev_i, seq_i, alt_asc_i, alt_desc_i, sg_ui, sg_si;
  logic  seen;

  initial begin
    for (int i = 0; i < int'(N); i++) begin
      rev_v[i]  = W'(9 - i);
      rev_i[i]  = IW'(9 - i);
      seq_v[i]  = W'(i);
      seq_i[i]  = IW'(i);
      five_v[i] = W'(5);
      alt_v[i]  = (i % 2 == 0) ? W'(3) : W'(1);
    end
    // 1s sit at odd indices, 3s at even; stable order within each group.
    for (int k = 0; k < 5; k++) begin
      alt_asc_d[k]    = W'(1);  alt_asc_i[k]    = IW'(2 * k + 1);
      alt_asc_d[k+5]  = W'(3);  alt_asc_i[k+5]  = IW'(2 * k);
      alt_desc_d[k]   = W'(3);  alt_desc_i[k]   = IW'(2 * k);
      alt_desc_d[k+5] = W'(1);  alt_desc_i[k+5] = IW'(2 * k + 1);
    end
    sg_v = '0; sg_v[0] = W'(1); sg_v[1] = W'(10'h3FF);
    for (int k = 0; k < 8; k++) begin
      sg_ud[k]   = '0; sg_ui[k]   = IW'(k + 2);
      sg_sd[k+1] = '0; sg_si[k+1] = IW'(k + 2);
    end
    sg_ud[8] = W'(1);         sg_ui[8] = IW'(0);
    sg_ud[9] = W'(10'h3FF);   sg_ui[9] = IW'(1);
    sg_sd[0] = W'(10'h3FF);   sg_si[0] = IW'(1);
    sg_sd[9] = W'(1);         sg_si[9] = IW'(0);

    rst = 1'b1; din = '0; desc_in = 1'b0; vld_in = 1'b0; rdy_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_data", 128'(u_data), 128'(0));
    check("rst_idx",  128'(u_idx),  128'(0));
    check("rst_desc", 128'(u_desc), 128'(0));
    check("rst_vld",  128'(u_vld),  128'(0));
    check("rst_rdy",  128'(u_rdy),  128'(1));

    run_vec("rev_asc",  rev_v,  1'b0, seq_v, rev_i, seq_v, rev_i);
    run_vec("rev_desc", rev_v,  1'b1, rev_v, seq_i, rev_v, seq_i);
    run_vec("eq_asc",   five_v, 1'b0, five_v, seq_i, five_v, seq_i);
    run_vec("eq_desc",  five_v, 1'b1, five_v, seq_i, five_v, seq_i);
    run_vec("alt_asc",  alt_v,  1'b0, alt_asc_d, alt_asc_i, alt_asc_d, alt_asc_i);
    run_vec("alt_desc", alt_v,  1'b1, alt_desc_d, alt_desc_i, alt_desc_d, alt_desc_i);
    run_vec("signed",   sg_v,   1'b0, sg_ud, sg_ui, sg_sd, sg_si);

    // Backpressure: three back-to-back vectors, stall four cycles on the first.
    begin
      int n;
      vld_in = 1'b1; din = rev_v; desc_in = 1'b0;
      tick();
      din = five_v; desc_in = 1'b1;
      tick();
      din = alt_v; desc_in = 1'b0;
      tick();
      vld_in = 1'b0; din = '0; desc_in = 1'b0;
      n = 0;
      while (!u_vld && n < 40) begin
        tick();
        n++;
      end
      check("bp_lat", 128'(n), 128'(N - 3));
      rdy_in = 1'b0;
      #1;
      check("bp_rdy_low", 128'(u_rdy), 128'(0));
      for (int c = 0; c < 4; c++) begin
        tick();
        check("bp_hold_vld",  128'(u_vld),  128'(1));
        check("bp_hold_data", 128'(u_data), 128'(seq_v));
        check("bp_hold_rdy",  128'(u_rdy),  128'(0));
      end
      check("bp_a_idx", 128'(u_idx), 128'(rev_i));
      rdy_in = 1'b1;
      #1;
      check("bp_rdy_high", 128'(u_rdy), 128'(1));
      tick();
      check("bp_b_vld",  128'(u_vld),  128'(1));
      check("bp_b_data", 128'(u_data), 128'(five_v));
      check("bp_b_idx",  128'(u_idx),  128'(seq_i));
      check("bp_b_desc", 128'(u_desc), 128'(1));
      tick();
      check("bp_c_vld",  128'(u_vld),  128'(1));
      check("bp_c_data", 128'(u_data), 128'(alt_asc_d));
      check("bp_c_idx",  128'(u_idx),  128'(alt_asc_i));
      tick();
      check("bp_end_vld", 128'(u_vld), 128'(0));
    end

    // Reset mid-flight, with a valid vector offered on the reset edge itself.
    vld_in = 1'b1; din = rev_v;
    tick();
    din = alt_v;
    tick();
    vld_in = 1'b0;
    tick();
    tick();
    rst = 1'b1; vld_in = 1'b1; din = five_v;
    tick();
    rst = 1'b0; vld_in = 1'b0; din = '0;
    check("mr_data", 128'(u_data), 128'(0));
    check("mr_idx",  128'(u_idx),  128'(0));
    check("mr_vld",  128'(u_vld),  128'(0));
    check("mr_rdy",  128'(u_rdy),  128'(1));
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      seen = seen | u_vld;
    end
    check("mr_flushed", 128'(seen), 128'(0));
    run_vec("post_rst", rev_v, 1'b1, rev_v, seq_i, rev_v, seq_i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
